// File: rtl/gemini_iq_pkg.sv
// Shared definitions for the issue instruction queue: default depth,
// per-field widths and the packed entry layout stored in iq_ram.
package gemini_iq_pkg;

  localparam int IQ_DEPTH   = 8;
  localparam int PC_W       = 32;
  localparam int INST_W     = 32;
  localparam int TGT_W      = 32;
  localparam int IQ_FLAG_W  = 3;
  localparam int IQ_ENTRY_W = PC_W + INST_W + 1 + TGT_W + IQ_FLAG_W;

  // One queued fetch slot; 32+32+1+32+3 = 100 bits
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              pred_taken;
    logic [TGT_W-1:0]  pred_target;
    logic              is_inst_adel;
    logic              is_i_refill_tlbl;
    logic              is_i_invalid_tlbl;
  } iq_entry_t;

endpackage

// File: rtl/iq_ram.sv
// Entry storage for the issue queue: DEPTH x IQ_ENTRY_W register array with
// two write ports (fetch slot 0 and 1) and one asynchronous read port (head).
// Contents are never reset; occupancy tracking lives in the parent.
module iq_ram
  import gemini_iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we0,
  input  logic [AW-1:0]         i_waddr0,
  input  logic [IQ_ENTRY_W-1:0] i_wdata0,
  input  logic                  i_we1,
  input  logic [AW-1:0]         i_waddr1,
  input  logic [IQ_ENTRY_W-1:0] i_wdata1,
  input  logic [AW-1:0]         i_raddr,
  output logic [IQ_ENTRY_W-1:0] o_rdata
);

  logic [IQ_ENTRY_W-1:0] r_mem [DEPTH];

  // Write both fetch slots; the parent guarantees distinct addresses
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/issue_inst_queue.sv
// Issue instruction queue between fetch and decode. Accepts up to two
// in-order fetch slots per cycle, presents the oldest entry show-ahead on
// the id1_* outputs and pops it when decode is not stalled. Both flush
// flavours and reset empty the queue without touching the storage.
module issue_inst_queue
  import gemini_iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     exception_flush,
  input  logic                     stall,
  input  logic                     if_w_ena0,
  input  logic                     if_w_ena1,
  input  logic [31:0]              if_pc0,
  input  logic [31:0]              if_pc1,
  input  logic [31:0]              if_inst0,
  input  logic [31:0]              if_inst1,
  input  logic                     if_pred_taken0,
  input  logic                     if_pred_taken1,
  input  logic [31:0]              if_pred_target0,
  input  logic [31:0]              if_pred_target1,
  input  logic                     if_is_inst_adel0,
  input  logic                     if_is_inst_adel1,
  input  logic                     if_is_i_refill_tlbl0,
  input  logic                     if_is_i_refill_tlbl1,
  input  logic                     if_is_i_invalid_tlbl0,
  input  logic                     if_is_i_invalid_tlbl1,
  output logic                     iq_full,
  output logic                     id1_valid_o,
  output logic [31:0]              id1_pc_o,
  output logic [31:0]              id1_inst_o,
  output logic                     id1_pred_taken_o,
  output logic [31:0]              id1_pred_target_o,
  output logic                     id1_is_inst_adel_o,
  output logic                     id1_is_i_refill_tlbl_o,
  output logic                     id1_is_i_invalid_tlbl_o,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - 1);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic            w_kill;
  logic            w_wr0;
  logic            w_wr1;
  logic            w_deq;
  logic [1:0]      w_nwr;
  iq_entry_t       w_wdata0;
  iq_entry_t       w_wdata1;
  iq_entry_t       w_head;
  logic [IQ_ENTRY_W-1:0] w_rdata;

  // Full is judged on the registered count so fetch sees a stable flag
  assign iq_full     = (r_count >= FULL_TH);
  assign id1_valid_o = (r_count != '0);
  assign iq_count    = r_count;

  // Any flush or reset cancels this cycle's enqueue and dequeue
  assign w_kill = rst | exception_flush | flush;
  assign w_wr0  = if_w_ena0 & ~iq_full & ~w_kill;
  assign w_wr1  = if_w_ena1 & if_w_ena0 & ~iq_full & ~w_kill;
  assign w_deq  = id1_valid_o & ~stall & ~w_kill;
  assign w_nwr  = {1'b0, w_wr0} + {1'b0, w_wr1};

  assign w_wdata0 = '{pc: if_pc0, inst: if_inst0, pred_taken: if_pred_taken0,
                      pred_target: if_pred_target0, is_inst_adel: if_is_inst_adel0,
                      is_i_refill_tlbl: if_is_i_refill_tlbl0,
                      is_i_invalid_tlbl: if_is_i_invalid_tlbl0};
  assign w_wdata1 = '{pc: if_pc1, inst: if_inst1, pred_taken: if_pred_taken1,
                      pred_target: if_pred_target1, is_inst_adel: if_is_inst_adel1,
                      is_i_refill_tlbl: if_is_i_refill_tlbl1,
                      is_i_invalid_tlbl: if_is_i_invalid_tlbl1};

  iq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .i_we0    (w_wr0),
    .i_waddr0 (r_tail),
    .i_wdata0 (w_wdata0),
    .i_we1    (w_wr1),
    .i_waddr1 (r_tail + AW'(1)),
    .i_wdata1 (w_wdata1),
    .i_raddr  (r_head),
    .o_rdata  (w_rdata)
  );

  // Pointer and occupancy control: rst, then exception_flush, then flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (exception_flush || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq);
      r_tail  <= r_tail + AW'(w_nwr);
      r_count <= r_count + CW'(w_nwr) - CW'(w_deq);
    end
  end

  // Head entry fields, forced to zero while the queue is empty
  assign w_head                  = iq_entry_t'(w_rdata);
  assign id1_pc_o                = id1_valid_o ? w_head.pc                : '0;
  assign id1_inst_o              = id1_valid_o ? w_head.inst              : '0;
  assign id1_pred_taken_o        = id1_valid_o ? w_head.pred_taken        : 1'b0;
  assign id1_pred_target_o       = id1_valid_o ? w_head.pred_target       : '0;
  assign id1_is_inst_adel_o      = id1_valid_o ? w_head.is_inst_adel      : 1'b0;
  assign id1_is_i_refill_tlbl_o  = id1_valid_o ? w_head.is_i_refill_tlbl  : 1'b0;
  assign id1_is_i_invalid_tlbl_o = id1_valid_o ? w_head.is_i_invalid_tlbl : 1'b0;

endmodule

// File: tb/tb_issue_inst_queue.sv
// Directed bench for issue_inst_queue (DEPTH = 8): reset, show-ahead
// ordering, fill to full under stall, pointer wrap with concurrent
// enqueue/dequeue, flush behaviour and flag pass-through.
module tb_issue_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, exception_flush, stall;
  logic        if_w_ena0, if_w_ena1;
  logic [31:0] if_pc0, if_pc1, if_inst0, if_inst1;
  logic        if_pred_taken0, if_pred_taken1;
  logic [31:0] if_pred_target0, if_pred_target1;
  logic        if_is_inst_adel0, if_is_inst_adel1;
  logic        if_is_i_refill_tlbl0, if_is_i_refill_tlbl1;
  logic        if_is_i_invalid_tlbl0, if_is_i_invalid_tlbl1;
  logic        iq_full, id1_valid_o;
  logic [31:0] id1_pc_o, id1_inst_o, id1_pred_target_o;
  logic        id1_pred_taken_o, id1_is_inst_adel_o;
  logic        id1_is_i_refill_tlbl_o, id1_is_i_invalid_tlbl_o;
  logic [3:0]  iq_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush),
    .stall(stall), .if_w_ena0(if_w_ena0), .if_w_ena1(if_w_ena1),
    .if_pc0(if_pc0), .if_pc1(if_pc1), .if_inst0(if_inst0), .if_inst1(if_inst1),
    .if_pred_taken0(if_pred_taken0), .if_pred_taken1(if_pred_taken1),
    .if_pred_target0(if_pred_target0), .if_pred_target1(if_pred_target1),
    .if_is_inst_adel0(if_is_inst_adel0), .if_is_inst_adel1(if_is_inst_adel1),
    .if_is_i_refill_tlbl0(if_is_i_refill_tlbl0), .if_is_i_refill_tlbl1(if_is_i_refill_tlbl1),
    .if_is_i_invalid_tlbl0(if_is_i_invalid_tlbl0), .if_is_i_invalid_tlbl1(if_is_i_invalid_tlbl1),
    .iq_full(iq_full), .id1_valid_o(id1_valid_o), .id1_pc_o(id1_pc_o),
    .id1_inst_o(id1_inst_o), .id1_pred_taken_o(id1_pred_taken_o),
    .id1_pred_target_o(id1_pred_target_o), .id1_is_inst_adel_o(id1_is_inst_adel_o),
    .id1_is_i_refill_tlbl_o(id1_is_i_refill_tlbl_o),
    .id1_is_i_invalid_tlbl_o(id1_is_i_invalid_tlbl_o), .iq_count(iq_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_w_ena0 = 0; if_w_ena1 = 0;
    if_pc0 = 0; if_pc1 = 0; if_inst0 = 0; if_inst1 = 0;
    if_pred_taken0 = 0; if_pred_taken1 = 0;
    if_pred_target0 = 0; if_pred_target1 = 0;
    if_is_inst_adel0 = 0; if_is_inst_adel1 = 0;
    if_is_i_refill_tlbl0 = 0; if_is_i_refill_tlbl1 = 0;
    if_is_i_invalid_tlbl0 = 0; if_is_i_invalid_tlbl1 = 0;
  endtask

  // Present a fetch group; inst words are the inverted PC for easy checking
  task automatic wr(input logic e0, input logic e1, input logic [31:0] p0, input logic [31:0] p1);
    idle();
    if_w_ena0 = e0; if_w_ena1 = e1;
    if_pc0 = p0; if_pc1 = p1; if_inst0 = ~p0; if_inst1 = ~p1;
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_count"}, 32'(iq_count), 32'd0);
    chk({tag, "_valid"}, 32'(id1_valid_o), 32'd0);
    chk({tag, "_pc"}, id1_pc_o, 32'd0);
    chk({tag, "_full"}, 32'(iq_full), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1; flush = 0; exception_flush = 0; stall = 0;
    step();
    step();
    rst = 0;
    check_empty("reset");
    chk("reset_inst", id1_inst_o, 32'd0);
    chk("reset_target", id1_pred_target_o, 32'd0);

    // Dual write into empty queue, then drain in program order
    wr(1, 1, 32'hBFC00000, 32'hBFC00004);
    step();
    idle();
    chk("dual_valid", 32'(id1_valid_o), 32'd1);
    chk("dual_pc0", id1_pc_o, 32'hBFC00000);
    chk("dual_inst0", id1_inst_o, ~32'hBFC00000);
    chk("dual_count", 32'(iq_count), 32'd2);
    step();
    chk("dual_pc1", id1_pc_o, 32'hBFC00004);
    chk("dual_inst1", id1_inst_o, ~32'hBFC00004);
    chk("dual_count1", 32'(iq_count), 32'd1);
    step();
    check_empty("drain1");

    // Prediction and exception flags pass through per slot
    stall = 1;
    wr(1, 1, 32'h1000, 32'h1004);
    if_pred_taken0 = 1; if_pred_target0 = 32'h80001000; if_is_i_refill_tlbl0 = 1;
    if_pred_target1 = 32'hDEAD0000; if_is_inst_adel1 = 1; if_is_i_invalid_tlbl1 = 1;
    step();
    idle();
    chk("flag0_pc", id1_pc_o, 32'h1000);
    chk("flag0_taken", 32'(id1_pred_taken_o), 32'd1);
    chk("flag0_target", id1_pred_target_o, 32'h80001000);
    chk("flag0_refill", 32'(id1_is_i_refill_tlbl_o), 32'd1);
    chk("flag0_adel", 32'(id1_is_inst_adel_o), 32'd0);
    chk("flag0_invalid", 32'(id1_is_i_invalid_tlbl_o), 32'd0);
    step();
    chk("stall_hold_pc", id1_pc_o, 32'h1000);
    chk("stall_hold_count", 32'(iq_count), 32'd2);
    stall = 0;
    step();
    chk("flag1_pc", id1_pc_o, 32'h1004);
    chk("flag1_taken", 32'(id1_pred_taken_o), 32'd0);
    chk("flag1_target", id1_pred_target_o, 32'hDEAD0000);
    chk("flag1_refill", 32'(id1_is_i_refill_tlbl_o), 32'd0);
    chk("flag1_adel", 32'(id1_is_inst_adel_o), 32'd1);
    chk("flag1_invalid", 32'(id1_is_i_invalid_tlbl_o), 32'd1);
    step();
    check_empty("drain2");
    chk("empty_flags", 32'(id1_is_inst_adel_o), 32'd0);

    // Fill to full while stalled; writes at full are ignored
    rst = 1;
    step();
    rst = 0;
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      wr(1, 1, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i));
      step();
      chk("fill_count", 32'(iq_count), 32'(2 * i + 2));
      chk("fill_full", 32'(iq_full), (i == 3) ? 32'd1 : 32'd0);
      chk("fill_head", id1_pc_o, 32'h100);
    end
    wr(1, 1, 32'h200, 32'h204);
    step();
    chk("full_ign_count", 32'(iq_count), 32'd8);
    chk("full_ign_head", id1_pc_o, 32'h100);
    idle();
    stall = 0;
    step();
    chk("c7_count", 32'(iq_count), 32'd7);
    chk("c7_full", 32'(iq_full), 32'd1);
    stall = 1;
    wr(1, 0, 32'h300, 32'h0);
    step();
    idle();
    chk("c7_ign_count", 32'(iq_count), 32'd7);
    stall = 0;
    for (int i = 0; i < 7; i++) begin
      chk("drain_full_pc", id1_pc_o, 32'h104 + 32'(4 * i));
      chk("drain_full_count", 32'(iq_count), 32'(7 - i));
      step();
    end
    check_empty("drain3");

    // Concurrent dual write and dequeue across the wrap (tail 7 -> 1)
    stall = 1;
    wr(1, 1, 32'h400, 32'h404); step();
    wr(1, 1, 32'h408, 32'h40C); step();
    wr(1, 1, 32'h410, 32'h414); step();
    wr(1, 0, 32'h418, 32'h0);   step();
    idle();
    chk("pre_wrap_count", 32'(iq_count), 32'd7);
    stall = 0;
    repeat (4) step();
    chk("wrap_c3_count", 32'(iq_count), 32'd3);
    chk("wrap_c3_pc", id1_pc_o, 32'h410);
    wr(1, 1, 32'h500, 32'h504);
    step();
    idle();
    chk("wrap_count", 32'(iq_count), 32'd4);
    chk("wrap_pc_a", id1_pc_o, 32'h414);
    step();
    chk("wrap_pc_b", id1_pc_o, 32'h418);
    step();
    chk("wrap_pc_c", id1_pc_o, 32'h500);
    chk("wrap_inst_c", id1_inst_o, ~32'h500);
    step();
    chk("wrap_pc_d", id1_pc_o, 32'h504);
    step();
    check_empty("drain4");

    // Flush with stall and a concurrent write empties the queue
    stall = 1;
    wr(1, 1, 32'h600, 32'h604); step();
    wr(1, 1, 32'h608, 32'h60C); step();
    wr(1, 0, 32'h610, 32'h0);   step();
    chk("pre_flush_count", 32'(iq_count), 32'd5);
    wr(1, 0, 32'h700, 32'h0);
    flush = 1;
    step();
    flush = 0;
    idle();
    check_empty("flush");
    wr(1, 0, 32'h710, 32'h0);
    step();
    idle();
    chk("post_flush_pc", id1_pc_o, 32'h710);
    chk("post_flush_count", 32'(iq_count), 32'd1);
    wr(1, 1, 32'h720, 32'h724);
    exception_flush = 1;
    step();
    exception_flush = 0;
    idle();
    check_empty("exc_flush");

    // Reset mid-operation at count 6, then first enqueue right after
    wr(1, 1, 32'h800, 32'h804); step();
    wr(1, 1, 32'h808, 32'h80C); step();
    wr(1, 1, 32'h810, 32'h814); step();
    chk("pre_rst_count", 32'(iq_count), 32'd6);
    wr(1, 0, 32'h820, 32'h0);
    rst = 1;
    step();
    rst = 0;
    idle();
    check_empty("mid_rst");
    wr(1, 0, 32'h900, 32'h0);
    step();
    idle();
    chk("post_rst_pc", id1_pc_o, 32'h900);
    chk("post_rst_count", 32'(iq_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
